// File: rtl/counter_bank.sv
// -----------------------------------------------------------------------------
// counter_bank
//
// Bank of NUM_CH independent loadable counters. Each counter has its own enable,
// load strobe, load value, limit value and 2-bit mode:
//   00 up-saturate, 01 up-wrap, 10 down-saturate, 11 down-wrap.
// A shared snapshot port captures every channel's count in the same cycle and
// holds the captured values until the consumer acknowledges them.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   cnt_en        per-channel count enable
//   load          per-channel load strobe (takes priority over counting)
//   load_cnt      per-channel load value, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   max_cnt       per-channel limit value, same packing
//   mode          per-channel mode, channel i at [2i +: 2]
//   count_out     per-channel count registers, same packing
//   terminal_cnt  per-channel level flag: count sits at its terminal value
//   tc_pulse      per-channel one-cycle flag: a count step reached terminal
//   snap_req      request to capture all counts
//   snap_ack      consumer acknowledge of the held snapshot
//   snap_valid    a snapshot is held
//   snap_out      captured counts, same packing as count_out
// -----------------------------------------------------------------------------
module counter_bank #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             cnt_en,
    input  logic [NUM_CH-1:0]             load,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] load_cnt,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] max_cnt,
    input  logic [2*NUM_CH-1:0]           mode,
    output logic [NUM_CH*COUNT_WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]             terminal_cnt,
    output logic [NUM_CH-1:0]             tc_pulse,
    input  logic                          snap_req,
    input  logic                          snap_ack,
    output logic                          snap_valid,
    output logic [NUM_CH*COUNT_WIDTH-1:0] snap_out
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

    // -------------------------------------------------------------------------
    // Per-channel counters
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [COUNT_WIDTH-1:0] cnt_reg;
            logic [COUNT_WIDTH-1:0] cnt_next;
            logic [COUNT_WIDTH-1:0] step_val;
            logic [COUNT_WIDTH-1:0] max_val;
            logic [COUNT_WIDTH-1:0] ld_val;
            logic [1:0]             md;
            logic                   step;
            logic                   lands_on_term;
            logic                   tc_reg;
            logic                   tc_next;

            assign max_val = max_cnt[gi*COUNT_WIDTH +: COUNT_WIDTH];
            assign ld_val  = load_cnt[gi*COUNT_WIDTH +: COUNT_WIDTH];
            assign md      = mode[2*gi +: 2];
            assign step    = cnt_en[gi] & ~load[gi];

            // Value a step would produce. The up-count increments are only taken
            // while cnt < max, so they can never pass through 2^COUNT_WIDTH; the
            // decrements are only taken while cnt > 0.
            always_comb begin
                step_val = cnt_reg;
                case (md)
                    2'b00: begin
                        if (cnt_reg < max_val) begin
                            step_val = cnt_reg + CNT_ONE;
                        end
                    end
                    2'b01: begin
                        if (cnt_reg >= max_val) begin
                            step_val = CNT_ZERO;
                        end else begin
                            step_val = cnt_reg + CNT_ONE;
                        end
                    end
                    2'b10: begin
                        if (cnt_reg != CNT_ZERO) begin
                            step_val = cnt_reg - CNT_ONE;
                        end
                    end
                    default: begin
                        if (cnt_reg == CNT_ZERO) begin
                            step_val = max_val;
                        end else begin
                            step_val = cnt_reg - CNT_ONE;
                        end
                    end
                endcase
            end

            // Terminal is 0 for the down modes and max_cnt for the up modes.
            assign lands_on_term = md[1] ? (step_val == CNT_ZERO)
                                         : (step_val == max_val);

            // Load wins over a step and never pulses. Wrap modes pulse on every
            // step that lands on terminal; saturating modes pulse only when the
            // count actually moved, so a hold at the limit stays quiet.
            always_comb begin
                cnt_next = cnt_reg;
                tc_next  = 1'b0;
                if (load[gi]) begin
                    cnt_next = ld_val;
                end else if (step) begin
                    cnt_next = step_val;
                    tc_next  = lands_on_term & (md[0] | (step_val != cnt_reg));
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= CNT_ZERO;
                    tc_reg  <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    tc_reg  <= tc_next;
                end
            end

            assign count_out[gi*COUNT_WIDTH +: COUNT_WIDTH] = cnt_reg;
            assign terminal_cnt[gi] = md[1] ? (cnt_reg == CNT_ZERO)
                                            : (cnt_reg == max_val);
            assign tc_pulse[gi]     = tc_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Snapshot: a request is accepted when nothing is held, or when the held
    // snapshot is being acknowledged in the same cycle (back-to-back capture).
    // snap_out only changes on a capture, so it is stable while snap_valid=1.
    // -------------------------------------------------------------------------
    logic                          snap_valid_reg;
    logic                          snap_valid_next;
    logic [NUM_CH*COUNT_WIDTH-1:0] snap_out_reg;
    logic [NUM_CH*COUNT_WIDTH-1:0] snap_out_next;
    logic                          snap_capture;

    assign snap_capture = snap_req & (~snap_valid_reg | snap_ack);

    always_comb begin
        snap_valid_next = snap_valid_reg;
        snap_out_next   = snap_out_reg;
        if (snap_capture) begin
            snap_valid_next = 1'b1;
            snap_out_next   = count_out;
        end else if (snap_ack) begin
            snap_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid_reg <= 1'b0;
            snap_out_reg   <= '0;
        end else begin
            snap_valid_reg <= snap_valid_next;
            snap_out_reg   <= snap_out_next;
        end
    end

    assign snap_valid = snap_valid_reg;
    assign snap_out   = snap_out_reg;

endmodule

// File: tb/tb_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_counter_bank
//
// Directed stimulus for counter_bank (4 channels, 8-bit counts). The stimulus
// process pushes hand-computed expectations tagged with the clock edge they
// belong to; a monitor process samples the outputs just after every rising
// edge, pops the expectations due for that edge and compares them.
// -----------------------------------------------------------------------------
module tb_counter_bank;

    localparam int N = 4;
    localparam int W = 8;

    localparam int K_CNT   = 0;
    localparam int K_TC    = 1;
    localparam int K_SV    = 2;
    localparam int K_SNAP  = 3;
    localparam int K_TERM  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     cnt_en;
    logic [N-1:0]     load;
    logic [N*W-1:0]   load_cnt;
    logic [N*W-1:0]   max_cnt;
    logic [2*N-1:0]   mode;
    logic [N*W-1:0]   count_out;
    logic [N-1:0]     terminal_cnt;
    logic [N-1:0]     tc_pulse;
    logic             snap_req;
    logic             snap_ack;
    logic             snap_valid;
    logic [N*W-1:0]   snap_out;

    always #5 clk = ~clk;

    counter_bank #(.NUM_CH(N), .COUNT_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt_en       (cnt_en),
        .load         (load),
        .load_cnt     (load_cnt),
        .max_cnt      (max_cnt),
        .mode         (mode),
        .count_out    (count_out),
        .terminal_cnt (terminal_cnt),
        .tc_pulse     (tc_pulse),
        .snap_req     (snap_req),
        .snap_ack     (snap_ack),
        .snap_valid   (snap_valid),
        .snap_out     (snap_out)
    );

    typedef struct {
        string       name;
        int          edge_idx;
        int          kind;
        int          ch;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   edge_no = 0;
    int   total   = 0;
    int   bad     = 0;

    // Expectation for the state seen right after the next rising edge.
    task automatic ex(input string n, input int k, input int c, input logic [31:0] v);
        exp_t e;
        e.name     = n;
        e.edge_idx = edge_no + 1;
        e.kind     = k;
        e.ch       = c;
        e.val      = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            #1;
            edge_no++;
            while (sb.size() > 0 && sb[0].edge_idx <= edge_no) begin
                e = sb.pop_front();
                total++;
                if (e.edge_idx < edge_no) begin
                    bad++;
                    $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)",
                             e.name, e.edge_idx, edge_no);
                end else begin
                    act = '0;
                    case (e.kind)
                        K_CNT:   act[W-1:0] = count_out[e.ch*W +: W];
                        K_TC:    act[N-1:0] = tc_pulse;
                        K_SV:    act[0]     = snap_valid;
                        K_SNAP:  act[W-1:0] = snap_out[e.ch*W +: W];
                        default: act[N-1:0] = terminal_cnt;
                    endcase
                    if (act !== e.val) begin
                        bad++;
                        $display("FAIL %s ch%0d edge %0d: got %0d required %0d",
                                 e.name, e.ch, edge_no, act, e.val);
                    end else begin
                        $display("ok   %s ch%0d edge %0d: %0d", e.name, e.ch, edge_no, act);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    int c0[8] = '{1, 2, 3, 4, 5, 5, 5, 5};
    int t0[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int c1[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int t1[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int c2[4] = '{0, 2, 1, 0};
    int t2[4] = '{4, 0, 0, 4};
    int s1[4] = '{4, 7, 2, 3};
    int s2[4] = '{5, 0, 2, 3};
    int s3[4] = '{5, 0, 2, 2};

    // Stimulus
    initial begin
        cnt_en   = '0;
        load     = '0;
        load_cnt = '0;
        snap_req = 1'b0;
        snap_ack = 1'b0;
        // ch0 up-sat max 5, ch1 up-wrap max 3, ch2 down-wrap max 2, ch3 down-sat max 10
        max_cnt  = {8'd10, 8'd2, 8'd3, 8'd5};
        mode     = {2'b10, 2'b11, 2'b01, 2'b00};

        // Reset with a load pending: reset must win
        rst  = 1'b1;
        load = 4'b1111;
        load_cnt = {8'd9, 8'd9, 8'd9, 8'd9};
        for (int c = 0; c < N; c++) ex("reset_cnt", K_CNT, c, 0);
        ex("reset_tc", K_TC, 0, 0);
        ex("reset_sv", K_SV, 0, 0);
        ex("reset_term", K_TERM, 0, 4'b1100);
        tick();
        rst  = 1'b0;
        load = '0;

        // ch0 saturating up and ch1 wrapping up, enable held 8 cycles
        cnt_en = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            ex("upsat_cnt", K_CNT, 0, c0[i]);
            ex("upwrap_cnt", K_CNT, 1, c1[i]);
            ex("up_tc", K_TC, 0, (t1[i] << 1) | t0[i]);
            if (i == 7) ex("up_term", K_TERM, 0, 4'b1101);
            tick();
        end

        // ch2 load 1, then down-wrap steps
        cnt_en   = 4'b0000;
        load     = 4'b0100;
        load_cnt = {8'd0, 8'd1, 8'd0, 8'd0};
        ex("dwrap_load_cnt", K_CNT, 2, 1);
        ex("dwrap_load_tc", K_TC, 0, 0);
        tick();
        load   = '0;
        cnt_en = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            ex("dwrap_cnt", K_CNT, 2, c2[i]);
            ex("dwrap_tc", K_TC, 0, t2[i]);
            tick();
        end

        // load and enable together on ch3: load wins, then one down step
        cnt_en   = 4'b1000;
        load     = 4'b1000;
        load_cnt = {8'd9, 8'd0, 8'd0, 8'd0};
        ex("load_vs_en_cnt", K_CNT, 3, 9);
        ex("load_vs_en_tc", K_TC, 0, 0);
        tick();
        load = '0;
        ex("dsat_step_cnt", K_CNT, 3, 8);
        tick();

        // Preload counts {4,7,2,3}
        cnt_en   = '0;
        load     = 4'b1111;
        load_cnt = {8'd3, 8'd2, 8'd7, 8'd4};
        for (int c = 0; c < N; c++) ex("preload_cnt", K_CNT, c, s1[c]);
        tick();
        load = '0;

        // First capture, ch0 steps 4->5 in the same cycle (pre-edge value captured)
        snap_req = 1'b1;
        cnt_en   = 4'b0001;
        ex("snap1_sv", K_SV, 0, 1);
        for (int c = 0; c < N; c++) ex("snap1_out", K_SNAP, c, s1[c]);
        ex("snap1_cnt", K_CNT, 0, 5);
        ex("snap1_tc", K_TC, 0, 4'b0001);
        tick();

        // Request without ack is ignored; ch1 wraps 7->0 (above max)
        cnt_en = 4'b0010;
        ex("snap_noack_sv", K_SV, 0, 1);
        for (int c = 0; c < N; c++) ex("snap_noack_out", K_SNAP, c, s1[c]);
        ex("wrap_above_max_cnt", K_CNT, 1, 0);
        ex("wrap_above_max_tc", K_TC, 0, 0);
        tick();

        // Request with ack: new capture
        cnt_en   = '0;
        snap_ack = 1'b1;
        ex("snap_reqack_sv", K_SV, 0, 1);
        for (int c = 0; c < N; c++) ex("snap_reqack_out", K_SNAP, c, s2[c]);
        tick();

        // Ack alone clears valid, data holds; ch3 steps 3->2
        snap_req = 1'b0;
        cnt_en   = 4'b1000;
        ex("snap_ack_sv", K_SV, 0, 0);
        for (int c = 0; c < N; c++) ex("snap_ack_out", K_SNAP, c, s2[c]);
        ex("dsat_cnt", K_CNT, 3, 2);
        tick();

        // Capture again while empty
        snap_req = 1'b1;
        snap_ack = 1'b0;
        cnt_en   = '0;
        ex("snap3_sv", K_SV, 0, 1);
        for (int c = 0; c < N; c++) ex("snap3_out", K_SNAP, c, s3[c]);
        tick();

        // Reset mid-run with snapshot held, enables and a load active
        snap_req = 1'b0;
        rst      = 1'b1;
        cnt_en   = 4'b1111;
        load     = 4'b1000;
        load_cnt = {8'd9, 8'd0, 8'd0, 8'd0};
        for (int c = 0; c < N; c++) ex("midrst_cnt", K_CNT, c, 0);
        for (int c = 0; c < N; c++) ex("midrst_snap", K_SNAP, c, 0);
        ex("midrst_sv", K_SV, 0, 0);
        ex("midrst_tc", K_TC, 0, 0);
        ex("midrst_term", K_TERM, 0, 4'b1100);
        tick();
        rst    = 1'b0;
        cnt_en = '0;
        load   = '0;

        tick();
        tick();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent counter channels (1..32).
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, width of each channel count (2..64).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cnt_en  input  NUM_CH  per-channel count enable.
REQ-006 SHALL have port load  input  NUM_CH  per-channel load strobe.
REQ-007 SHALL have port load_cnt  input  NUM_CH*COUNT_WIDTH  per-channel load value, channel i at bits [i*COUNT_WIDTH +: COUNT_WIDTH].
REQ-008 SHALL have port max_cnt  input  NUM_CH*COUNT_WIDTH  per-channel terminal/limit value, same packing.
REQ-009 SHALL have port mode  input  2*NUM_CH  per-channel mode, channel i at bits [2i +: 2]: 00 up-saturate, 01 up-wrap, 10 down-saturate, 11 down-wrap.
REQ-010 SHALL have port count_out  output  NUM_CH*COUNT_WIDTH  current count registers, same packing.
REQ-011 SHALL have port terminal_cnt  output  NUM_CH  per-channel level flag, count at terminal value.
REQ-012 SHALL have port tc_pulse  output  NUM_CH  per-channel one-cycle flag, a count step reached the terminal value.
REQ-013 SHALL have port snap_req  input  1  request to capture all channel counts simultaneously.
REQ-014 SHALL have port snap_ack  input  1  consumer acknowledge of the snapshot.
REQ-015 SHALL have port snap_valid  output  1  snapshot held and valid.
REQ-016 SHALL have port snap_out  output  NUM_CH*COUNT_WIDTH  captured counts, same packing.

Function
REQ-017 Per-channel priority SHALL be rst > load > count step; a "step" is cnt_en=1 with load=0 and rst=0.
REQ-018 load=1 SHALL set the count to load_cnt on the next edge regardless of cnt_en or mode; loads SHALL NOT assert tc_pulse.
REQ-019 Mode 00: step with cnt<max_cnt SHALL increment by 1; otherwise count holds.
REQ-020 Mode 01: step with cnt>=max_cnt SHALL set count to 0; otherwise SHALL increment by 1.
REQ-021 Mode 10: step with cnt>0 SHALL decrement by 1; at 0 count holds.
REQ-022 Mode 11: step with cnt==0 SHALL set count to max_cnt; otherwise SHALL decrement by 1.
REQ-023 Arithmetic SHALL be COUNT_WIDTH unsigned; the count SHALL never wrap through 2^COUNT_WIDTH.
REQ-024 terminal_cnt SHALL be combinational from the count register: modes 00/01 cnt==max_cnt; modes 10/11 cnt==0.
REQ-025 tc_pulse[i] SHALL be registered, high exactly in the cycle count_out first shows the terminal value produced by a step; a saturating hold SHALL NOT re-pulse; in wrap modes every step landing on terminal SHALL pulse.
REQ-026 mode and max_cnt changes SHALL take effect on the next step with no other side effect.
REQ-027 snap_req=1 with snap_valid=0, or with snap_valid=1 and snap_ack=1, SHALL capture the pre-edge count_out of all channels into snap_out and set snap_valid=1 on the next edge.
REQ-028 snap_ack=1 with snap_req=0 SHALL clear snap_valid on the next edge; snap_out SHALL hold its value.
REQ-029 snap_req with snap_valid=1 and snap_ack=0 SHALL be ignored; snap_out SHALL remain stable while snap_valid=1.
REQ-030 Channels SHALL be fully independent; any combination of simultaneous events across channels SHALL be legal.

Reset
REQ-031 rst=1 SHALL on the next edge set every count to 0 and tc_pulse, snap_valid and snap_out to 0, overriding load, step and snapshot.
REQ-032 rst asserted mid-operation SHALL discard any held snapshot; terminal_cnt after reset SHALL follow REQ-024 (down modes read 1, up modes read 1 only when max_cnt=0).

Verification
REQ-033 Ch0 mode 00, max_cnt=5, cnt_en held 8 cycles from 0 -> counts 1..5 then holds 5; tc_pulse single cycle with count_out=5.
REQ-034 Ch1 mode 01, max_cnt=3, cnt_en held -> 1,2,3,0,1,...; tc_pulse each time count_out=3.
REQ-035 Ch2 mode 11, max_cnt=2, load_cnt=1, load one cycle then cnt_en held -> 1,0,2,1,0; no tc_pulse on load; tc_pulse when count_out=0 after a step.
REQ-036 load and cnt_en same cycle, load_cnt=9 -> count 9, no increment; rst with load same cycle -> count 0.
REQ-037 snap_req with counts {4,7,..} -> next cycle snap_valid=1, snap_out={4,7,..}; second snap_req without ack ignored; snap_req+snap_ack together -> new capture.
REQ-038 rst while snap_valid=1 and counters mid-run -> next cycle all counts 0, snap_valid=0, tc_pulse=0.
